// File: rtl/piano_mode_ctrl_if.sv
// ---------------------------------------------------------------------------
// piano_mode_ctrl_if
//
// Groups the front-panel, keyboard and controller-status signals of the piano
// mode controller so they can be passed around as a single port.
//
//   btn_next     raw "advance cursor" button level
//   btn_confirm  raw "enter mode" button level
//   btn_back     raw "leave mode" button level
//   setting      raw remap request level
//   key_in       raw key levels, one bit per key
//   cursor       highlighted mode index (to the display decoder)
//   mode_en      one-hot enable of the running mode engine
//   remap_busy   high while the key remap table is being rebuilt
//   key_map      flattened key->note-slot table, slice k = slot of key k
//   note_out     remapped debounced keys for the active engine
//
// Modports: master = board side (drives buttons/keys, observes status),
//           slave  = the controller itself.
// N_MODES / N_KEYS must match the parameters of the attached controller.
// ---------------------------------------------------------------------------
interface piano_mode_ctrl_if #(
    parameter int N_MODES = 4,
    parameter int N_KEYS  = 8
);
    localparam int MW = $clog2(N_MODES);
    localparam int KW = $clog2(N_KEYS);

    logic                   btn_next;
    logic                   btn_confirm;
    logic                   btn_back;
    logic                   setting;
    logic [N_KEYS-1:0]      key_in;
    logic [MW-1:0]          cursor;
    logic [N_MODES-1:0]     mode_en;
    logic                   remap_busy;
    logic [N_KEYS*KW-1:0]   key_map;
    logic [N_KEYS-1:0]      note_out;

    modport master (
        output btn_next, btn_confirm, btn_back, setting, key_in,
        input  cursor, mode_en, remap_busy, key_map, note_out
    );

    modport slave (
        input  btn_next, btn_confirm, btn_back, setting, key_in,
        output cursor, mode_en, remap_busy, key_map, note_out
    );
endinterface

// File: rtl/piano_mode_ctrl.sv
// ---------------------------------------------------------------------------
// piano_mode_ctrl
//
// Top-level mode controller of the FPGA piano. Every raw button/key level is
// synchronised and debounced; rising edges of the debounced levels drive a
// three-state controller:
//   MENU  - btn_next cycles the cursor over N_MODES modes, btn_confirm enters
//           RUN, a held "setting" level enters REMAP.
//   RUN   - one-hot enable of the highlighted mode engine, debounced keys are
//           forwarded through the key->note table; btn_back returns to MENU.
//   REMAP - keys pressed in order receive note slots 0,1,2,...; once every
//           key has a slot the new table is committed. Dropping "setting"
//           before that aborts and keeps the old table.
//
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  piano_mode_ctrl_if.slave (buttons/keys in, cursor/mode_en/
//        remap_busy/key_map/note_out out)
//
// Parameters:
//   N_MODES    number of selectable modes (>= 2)
//   N_KEYS     number of keys and note slots (>= 2)
//   DB_CYCLES  debounce stability window in clk cycles
// ---------------------------------------------------------------------------
module piano_mode_ctrl #(
    parameter int N_MODES   = 4,
    parameter int N_KEYS    = 8,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    piano_mode_ctrl_if.slave bus
);
    localparam int MW  = $clog2(N_MODES);
    localparam int KW  = $clog2(N_KEYS);
    // Debounced inputs: bit 0 next, 1 confirm, 2 back, 3 setting, 4.. keys.
    localparam int NIN = 4 + N_KEYS;
    localparam int CW  = $clog2(DB_CYCLES + 1);

    localparam logic [MW-1:0]      LAST_MODE = MW'(N_MODES - 1);
    localparam logic [KW-1:0]      LAST_SLOT = KW'(N_KEYS - 1);
    localparam logic [CW-1:0]      DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [N_MODES-1:0] MODE_ONE  = {{(N_MODES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_MENU  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REMAP = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Synchroniser + debouncer per raw input
    // -----------------------------------------------------------------------
    logic [NIN-1:0] raw_in;
    logic [NIN-1:0] db_lvl;

    assign raw_in = {bus.key_in, bus.setting, bus.btn_back, bus.btn_confirm, bus.btn_next};

    genvar gi;
    generate
        for (gi = 0; gi < NIN; gi++) begin : g_db
            logic          sync1_reg;
            logic          sync2_reg;
            logic          lvl_reg;
            logic [CW-1:0] cnt_reg;

            // The debounced level only follows the synchronised input after
            // DB_CYCLES consecutive samples that disagree with it; a single
            // agreeing sample (a bounce back) restarts the count.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    lvl_reg   <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw_in[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == lvl_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        lvl_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign db_lvl[gi] = lvl_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Rise pulses from the debounced levels
    // -----------------------------------------------------------------------
    logic [2:0]        btn_prev_reg;
    logic [N_KEYS-1:0] key_prev_reg;
    logic              next_p;
    logic              conf_p;
    logic              back_p;
    logic              set_lvl;
    logic [N_KEYS-1:0] key_db;
    logic [N_KEYS-1:0] key_p;

    assign next_p  = db_lvl[0] & ~btn_prev_reg[0];
    assign conf_p  = db_lvl[1] & ~btn_prev_reg[1];
    assign back_p  = db_lvl[2] & ~btn_prev_reg[2];
    assign set_lvl = db_lvl[3];
    assign key_db  = db_lvl[NIN-1:4];
    assign key_p   = key_db & ~key_prev_reg;

    // -----------------------------------------------------------------------
    // Controller state
    // -----------------------------------------------------------------------
    // map_reg is the live table. It is left untouched throughout REMAP, so it
    // doubles as the shadow copy: abort simply keeps it, commit overwrites it
    // with new_reg, the table being rebuilt.
    state_t             state_reg,   state_next;
    logic [MW-1:0]      cursor_reg,  cursor_next;
    logic [KW-1:0]      map_reg     [N_KEYS];
    logic [KW-1:0]      map_next    [N_KEYS];
    logic [KW-1:0]      new_reg     [N_KEYS];
    logic [KW-1:0]      new_next    [N_KEYS];
    logic [N_KEYS-1:0]  asg_reg,     asg_next;
    logic [KW-1:0]      slot_reg,    slot_next;
    logic [N_MODES-1:0] mode_en_reg, mode_en_next;
    logic [N_KEYS-1:0]  note_reg,    note_next;

    // Lowest-index rising key that does not have a slot yet; other keys
    // rising in the same cycle are dropped.
    logic [N_KEYS-1:0]  key_cand;
    logic               pick_valid;
    logic [KW-1:0]      pick_idx;

    always_comb begin
        key_cand   = key_p & ~asg_reg;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            if (key_cand[k]) begin
                pick_valid = 1'b1;
                pick_idx   = KW'(k);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        cursor_next = cursor_reg;
        map_next    = map_reg;
        new_next    = new_reg;
        asg_next    = asg_reg;
        slot_next   = slot_reg;

        case (state_reg)
            ST_MENU: begin
                if (conf_p) begin
                    state_next = ST_RUN;
                end else begin
                    if (next_p) begin
                        cursor_next = (cursor_reg == LAST_MODE) ? '0 : cursor_reg + 1'b1;
                    end
                    if (set_lvl) begin
                        state_next = ST_REMAP;
                        new_next   = map_reg;
                        asg_next   = '0;
                        slot_next  = '0;
                    end
                end
            end

            ST_RUN: begin
                if (back_p) begin
                    state_next = ST_MENU;
                end
            end

            ST_REMAP: begin
                // Abort wins over a key arriving in the same cycle, even the
                // one that would have completed the table.
                if (!set_lvl) begin
                    state_next = ST_MENU;
                end else if (pick_valid) begin
                    new_next[pick_idx] = slot_reg;
                    asg_next[pick_idx] = 1'b1;
                    if (slot_reg == LAST_SLOT) begin
                        map_next   = new_next;
                        state_next = ST_MENU;
                    end else begin
                        slot_next = slot_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_MENU;
            end
        endcase

        // Outputs are registered from the next state so they change on the
        // same edge as the state itself.
        mode_en_next = '0;
        if (state_next == ST_RUN) begin
            mode_en_next = MODE_ONE << cursor_next;
        end

        note_next = '0;
        if (state_next == ST_RUN) begin
            for (int k = 0; k < N_KEYS; k++) begin
                note_next[map_reg[k]] = note_next[map_reg[k]] | key_db[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_MENU;
            cursor_reg   <= '0;
            asg_reg      <= '0;
            slot_reg     <= '0;
            mode_en_reg  <= '0;
            note_reg     <= '0;
            btn_prev_reg <= '0;
            key_prev_reg <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                map_reg[k] <= KW'(k);
                new_reg[k] <= KW'(k);
            end
        end else begin
            state_reg    <= state_next;
            cursor_reg   <= cursor_next;
            asg_reg      <= asg_next;
            slot_reg     <= slot_next;
            mode_en_reg  <= mode_en_next;
            note_reg     <= note_next;
            btn_prev_reg <= db_lvl[2:0];
            key_prev_reg <= key_db;
            map_reg      <= map_next;
            new_reg      <= new_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.cursor     = cursor_reg;
    assign bus.mode_en    = mode_en_reg;
    assign bus.remap_busy = (state_reg == ST_REMAP);
    assign bus.note_out   = note_reg;

    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_map_out
            assign bus.key_map[gi*KW +: KW] = map_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_piano_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_piano_mode_ctrl
//
// Self-checking bench for piano_mode_ctrl (N_MODES=4, N_KEYS=8, DB_CYCLES=4):
// hand-written debounce timing check, a directed vector table, randomized
// operations against an abstract reference model, and a multi-key /
// reset-during-remap sequence.
// ---------------------------------------------------------------------------
module tb_piano_mode_ctrl;
    localparam int NM     = 4;
    localparam int NK     = 8;
    localparam int DB     = 4;
    localparam int SETTLE = DB + 6;

    // key_map values as octal digits: digit k = note slot of key k
    localparam int ID    = 'o76543210;
    localparam int REV   = 'o01234567;
    localparam int MULTI = 'o76514032;

    localparam int OP_NEXT = 0;
    localparam int OP_CONF = 1;
    localparam int OP_BACK = 2;
    localparam int OP_NC   = 3;
    localparam int OP_SET  = 4;
    localparam int OP_KEYS = 5;
    localparam int OP_KEY  = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    piano_mode_ctrl_if #(.N_MODES(NM), .N_KEYS(NK)) bus ();

    piano_mode_ctrl #(.N_MODES(NM), .N_KEYS(NK), .DB_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int op;
        int arg;
        int cur;
        int me;
        int busy;
        int map;
        int note;
    } vec_t;

    vec_t tbl[$];

    // ---------------- reference model (abstract) ----------------
    int m_state;            // 0 menu, 1 run, 2 remap
    int m_cur;
    int m_live[NK];
    int m_new[NK];
    bit m_asg[NK];
    int m_slot;
    bit m_set;

    function automatic void m_reset();
        m_state = 0;
        m_cur   = 0;
        m_slot  = 0;
        m_set   = 1'b0;
        for (int k = 0; k < NK; k++) begin
            m_live[k] = k;
            m_new[k]  = k;
            m_asg[k]  = 1'b0;
        end
    endfunction

    // Level rule applied continuously: setting high in MENU starts a remap,
    // setting low during a remap aborts it.
    function automatic void m_level();
        if (m_state == 2 && !m_set) m_state = 0;
        if (m_state == 0 && m_set) begin
            m_state = 2;
            m_slot  = 0;
            for (int k = 0; k < NK; k++) m_asg[k] = 1'b0;
        end
    endfunction

    function automatic void m_event(input int kind, input int mask);
        case (kind)
            0: if (m_state == 0) m_cur = (m_cur + 1) % NM;
            1: if (m_state == 0) m_state = 1;
            2: if (m_state == 1) m_state = 0;
            3: if (m_state == 2) begin
                for (int k = 0; k < NK; k++) begin
                    if (mask[k] && !m_asg[k]) begin
                        m_new[k] = m_slot;
                        m_asg[k] = 1'b1;
                        m_slot++;
                        if (m_slot == NK) begin
                            m_live  = m_new;
                            m_state = 0;
                        end
                        break;
                    end
                end
            end
            default: ;
        endcase
        m_level();
    endfunction

    function automatic int m_map();
        int r = 0;
        for (int k = 0; k < NK; k++) r |= m_live[k] << (3 * k);
        return r;
    endfunction

    function automatic int m_note(input int mask);
        int r = 0;
        if (m_state != 1) return 0;
        for (int k = 0; k < NK; k++) if (mask[k]) r |= 1 << m_live[k];
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int cur, input int me,
                             input int busy, input int map, input int note);
        check({tag, ".cursor"},     int'(bus.cursor),     cur);
        check({tag, ".mode_en"},    int'(bus.mode_en),    me);
        check({tag, ".remap_busy"}, int'(bus.remap_busy), busy);
        check({tag, ".key_map"},    int'(bus.key_map),    map);
        check({tag, ".note_out"},   int'(bus.note_out),   note);
    endtask

    task automatic check_model(input string tag, input int mask);
        check_out(tag, m_cur, (m_state == 1) ? (1 << m_cur) : 0,
                  (m_state == 2) ? 1 : 0, m_map(), m_note(mask));
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.btn_next    = 1'b0;
        bus.btn_confirm = 1'b0;
        bus.btn_back    = 1'b0;
        bus.setting     = 1'b0;
        bus.key_in      = '0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic apply(input int op, input int arg);
        case (op)
            OP_NEXT: begin bus.btn_next = 1'b1; tick(SETTLE); bus.btn_next = 1'b0; tick(SETTLE); end
            OP_CONF: begin bus.btn_confirm = 1'b1; tick(SETTLE); bus.btn_confirm = 1'b0; tick(SETTLE); end
            OP_BACK: begin bus.btn_back = 1'b1; tick(SETTLE); bus.btn_back = 1'b0; tick(SETTLE); end
            OP_NC: begin
                bus.btn_next = 1'b1; bus.btn_confirm = 1'b1; tick(SETTLE);
                bus.btn_next = 1'b0; bus.btn_confirm = 1'b0; tick(SETTLE);
            end
            OP_SET:  begin bus.setting = arg[0]; tick(SETTLE); end
            OP_KEYS: begin bus.key_in = arg[7:0]; tick(SETTLE); end
            OP_KEY:  begin bus.key_in = 8'(1 << arg); tick(SETTLE); bus.key_in = '0; tick(SETTLE); end
            default: ;
        endcase
    endtask

    // ---------------- test ----------------
    initial begin
        int lat;
        int order[7];

        // Directed vectors: {op, arg, cursor, mode_en, busy, key_map, note_out}
        tbl.push_back('{OP_NEXT, 0,    1, 0,      0, ID,  0});
        tbl.push_back('{OP_NEXT, 0,    2, 0,      0, ID,  0});
        tbl.push_back('{OP_NEXT, 0,    3, 0,      0, ID,  0});
        tbl.push_back('{OP_NEXT, 0,    0, 0,      0, ID,  0});
        tbl.push_back('{OP_NC,   0,    0, 'b0001, 0, ID,  0});
        tbl.push_back('{OP_BACK, 0,    0, 0,      0, ID,  0});
        tbl.push_back('{OP_NEXT, 0,    1, 0,      0, ID,  0});
        tbl.push_back('{OP_NEXT, 0,    2, 0,      0, ID,  0});
        tbl.push_back('{OP_CONF, 0,    2, 'b0100, 0, ID,  0});
        tbl.push_back('{OP_KEYS, 'h01, 2, 'b0100, 0, ID,  'h01});
        tbl.push_back('{OP_KEYS, 'h00, 2, 'b0100, 0, ID,  'h00});
        tbl.push_back('{OP_KEYS, 'h01, 2, 'b0100, 0, ID,  'h01});
        tbl.push_back('{OP_BACK, 0,    2, 0,      0, ID,  0});
        tbl.push_back('{OP_KEYS, 'h00, 2, 0,      0, ID,  0});
        tbl.push_back('{OP_SET,  1,    2, 0,      1, ID,  0});
        for (int k = 7; k >= 1; k--) tbl.push_back('{OP_KEY, k, 2, 0, 1, ID, 0});
        // completion commits; setting still high so REMAP is re-entered
        tbl.push_back('{OP_KEY,  0,    2, 0,      1, REV, 0});
        tbl.push_back('{OP_SET,  0,    2, 0,      0, REV, 0});
        tbl.push_back('{OP_CONF, 0,    2, 'b0100, 0, REV, 0});
        tbl.push_back('{OP_KEYS, 'h01, 2, 'b0100, 0, REV, 'h80});
        tbl.push_back('{OP_KEYS, 'h00, 2, 'b0100, 0, REV, 0});
        tbl.push_back('{OP_BACK, 0,    2, 0,      0, REV, 0});
        tbl.push_back('{OP_SET,  1,    2, 0,      1, REV, 0});
        tbl.push_back('{OP_KEY,  3,    2, 0,      1, REV, 0});
        tbl.push_back('{OP_KEY,  5,    2, 0,      1, REV, 0});
        tbl.push_back('{OP_KEY,  3,    2, 0,      1, REV, 0});
        tbl.push_back('{OP_SET,  0,    2, 0,      0, REV, 0});

        // Reset state
        do_reset();
        check_out("reset", 0, 0, 0, ID, 0);

        // Debounce: 3-cycle glitches never register, stable press lands 7 edges later
        for (int g = 0; g < 3; g++) begin
            bus.btn_next = 1'b1;
            for (int c = 0; c < 3; c++) begin tick(1); check("glitch_hi.cursor", int'(bus.cursor), 0); end
            bus.btn_next = 1'b0;
            for (int c = 0; c < 3; c++) begin tick(1); check("glitch_lo.cursor", int'(bus.cursor), 0); end
        end
        bus.btn_next = 1'b1;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (lat == 0 && bus.cursor == 2'd1) lat = i;
        end
        check("db_latency", lat, 7);
        bus.btn_next = 1'b0;
        tick(SETTLE);
        check("db_final.cursor", int'(bus.cursor), 1);

        // Directed table
        do_reset();
        foreach (tbl[i]) begin
            apply(tbl[i].op, tbl[i].arg);
            check_out($sformatf("vec%0d", i), tbl[i].cur, tbl[i].me,
                      tbl[i].busy, tbl[i].map, tbl[i].note);
        end

        // Randomized operations against the reference model
        do_reset();
        m_reset();
        for (int i = 0; i < 90; i++) begin
            int r;
            int mask;
            r = int'($urandom_range(0, 11));
            if (r <= 1) begin
                apply(OP_NEXT, 0); m_event(0, 0); check_model("rnd_next", 0);
            end else if (r == 2) begin
                apply(OP_CONF, 0); m_event(1, 0); check_model("rnd_conf", 0);
            end else if (r == 3) begin
                apply(OP_BACK, 0); m_event(2, 0); check_model("rnd_back", 0);
            end else if (r == 4) begin
                m_set = !m_set;
                apply(OP_SET, int'(m_set)); m_level(); check_model("rnd_set", 0);
            end else begin
                if ($urandom_range(0, 9) < 7) mask = 1 << $urandom_range(0, NK - 1);
                else mask = int'($urandom_range(1, 255));
                apply(OP_KEYS, mask); m_event(3, mask); check_model("rnd_key_hold", mask);
                apply(OP_KEYS, 0);    check_model("rnd_key_rel", 0);
            end
        end

        // Multi-key press in REMAP, then reset during REMAP
        do_reset();
        apply(OP_NEXT, 0);
        apply(OP_SET, 1);
        check_out("multi_enter", 1, 0, 1, ID, 0);
        apply(OP_KEYS, 'b0001_0100);
        apply(OP_KEYS, 0);
        order = '{4, 0, 1, 3, 5, 6, 7};
        foreach (order[i]) apply(OP_KEY, order[i]);
        check_out("multi_commit", 1, 0, 1, MULTI, 0);
        apply(OP_KEY, 1);
        rst = 1'b1;
        #2;
        check_out("reset_mid", 0, 0, 0, ID, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check_out("after_reset", 0, 0, 0, ID, 0);
        bus.setting = 1'b0;
        tick(SETTLE);
        check_out("idle", 0, 0, 0, ID, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/piano_mode_ctrl.md
# piano_mode_ctrl

Parametrised top-level mode controller for the FPGA piano. It debounces the front-panel buttons and cycles a menu cursor over `N_MODES` playable modes, then issues a one-hot enable to the selected mode engine. It also owns a run-time key-to-note remap table for `N_KEYS` keys, with abort/restore, and forwards the remapped key vector to the active engine. It sits between the board I/O and the FREE/AUTO/LERN mode modules.

## Interface
- `N_MODES`, default 4: number of selectable modes, minimum 2.
- `N_KEYS`, default 8: number of keyboard keys and note slots, minimum 2.
- `DB_CYCLES`, default 1_000_000: debounce stability window in clk cycles (10 ms at 100 MHz).
- localparam `MW = clog2(N_MODES)`; `KW = clog2(N_KEYS)`.

- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `btn_next` in 1: advance menu cursor (raw).
- `btn_confirm` in 1: enter highlighted mode (raw).
- `btn_back` in 1: leave running mode (raw).
- `setting` in 1: remap request level (raw).
- `key_in` in N_KEYS: raw key levels.
- `cursor` out MW: highlighted mode index, for the display decoder.
- `mode_en` out N_MODES: one-hot enable of the running mode; all-zero when not in RUN.
- `remap_busy` out 1: high while in REMAP.
- `key_map` out N_KEYS*KW: flattened table; slice k is the note slot of key k.
- `note_out` out N_KEYS: remapped debounced keys; zero outside RUN.

## Operation
- All raw inputs pass through a 2-FF synchroniser, then a per-input debouncer. The debounced level takes the synchronised value only after it has differed from the current debounced value for `DB_CYCLES` consecutive cycles. The counter restarts on any bounce.
- Rise pulses (`next_p`, `conf_p`, `back_p`, `key_p[k]`) are one cycle wide and are generated from the debounced levels.
- FSM states are MENU, RUN and REMAP.
- MENU:
  - `next_p`: cursor = cursor+1, wrapping `N_MODES-1` to 0.
  - `conf_p`: go to RUN.
  - `conf_p` has priority over `next_p` in the same cycle.
  - Debounced `setting` high (level), with no `conf_p` in that cycle: go to REMAP.
  - `back_p` is ignored.
- RUN:
  - `mode_en = 1 << cursor`.
  - `note_out[key_map[k]] = key_db[k]` for every k.
  - `back_p`: go to MENU.
  - `next_p`, `conf_p` and `setting` are ignored.
- REMAP:
  - On entry, copy the live table to a shadow copy, mark all keys unassigned and set slot counter `s = 0`.
  - Each `key_p[k]` on an unassigned key: `map[k] = s`, mark k assigned, `s = s+1`.
  - If several rise in one cycle, only the lowest index is taken; the others are dropped.
  - `key_p` on an already-assigned key is ignored.
  - When `s` reaches `N_KEYS`: go to MENU with the new table committed.
  - Debounced `setting` low before completion: abort, restore the shadow table, go to MENU.
  - `key_map` shows the shadow (old) table for the whole of REMAP; the new table becomes visible on commit.
  - `note_out` = 0 throughout.
- Reset values: state MENU, `cursor` 0, `mode_en` 0, `remap_busy` 0, `note_out` 0, `key_map` identity (slice k = k), all debounced levels 0, all debounce counters 0.
- Reset mid-REMAP discards both tables and restores identity.

## Timing
- A raw level change held stable appears on the debounced level 2 + `DB_CYCLES` cycles later. The pulse is asserted in the following cycle.
- The state, `cursor` and `remap_busy` update on the clock edge that samples the pulse; they are registered outputs.
- `mode_en` and `note_out` are registered. `note_out` follows `key_db` with one cycle of latency.
- `mode_en` is all-zero from the first MENU cycle onward.
- In REMAP the abort is evaluated before key assignment. A completing key and a `setting` fall in the same cycle therefore abort.
- `remap_busy` rises on the REMAP entry edge and falls on the exit edge.

## Test plan
Run all scenarios with `DB_CYCLES` = 4 and `N_MODES` = 4.
- **Debounce:** toggle `btn_next` with 3-cycle glitches, then hold for 10 cycles. Required: `cursor` stays 0 during the glitches, then goes to 1 exactly 7 cycles after the stable edge.
- **Wrap and priority:** press `next` 4 times → `cursor` back at 0. Press `next` and `confirm` together → `cursor` stays 0, `mode_en` = 4'b0001.
- **Run/back:** with `cursor` = 2, confirm → `mode_en` = 4'b0100. `key_in` = 8'b0000_0001 → `note_out` = 8'b0000_0001. Back → `mode_en` = 0, `note_out` = 0.
- **Full remap:** setting high, press keys 7,6,…,0 in order → `key_map` slice k = 7-k, `remap_busy` falls. In RUN, key 0 → `note_out` = 8'b1000_0000.
- **Abort:** setting high, press keys 3 and 5, press key 3 again (ignored), drop setting → `key_map` unchanged from before entry.
- **Reset mid-remap and multi-key:** in REMAP, press keys 2 and 4 simultaneously → only key 2 assigned slot 0. Assert `rst` → identity map, MENU, all outputs zero.
